// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream valid/ready channel that feeds the program loader.
// The master drives bytes; the slave (the loader) answers with byte_ready.
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: run-time writable 256 x 16 program memory.
// Accepts a framed byte stream (length header N meaning N+1 words, then
// big-endian HI/LO byte pairs) and writes words to consecutive addresses
// from 0. The read port (address -> data) is asynchronous, like the ROM's.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte and drives the error output; without it error is constant 0.
module prog_loader #(
  parameter int DEPTH = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  prog_loader_if.slave stream,
  input  logic [7:0]   address,
  output logic [15:0]  data,
  output logic         busy,
  output logic         done,
  output logic [8:0]   word_count,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        byte_ready_r;
  logic        busy_r;
  logic        done_r;
  logic [8:0]  word_count_r;
  logic [8:0]  len_r;
  logic [7:0]  hi_r;
  logic        ready_next_s;
  logic        accept_s;
  logic        start_ok_s;
  logic        last_word_s;
  logic [15:0] mem_r [0:DEPTH-1];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc_r;
  logic        error_r;
`endif

  // A byte moves only when valid meets the registered ready.
  assign accept_s    = stream.byte_valid && byte_ready_r;
  assign start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign last_word_s = ((word_count_r + 9'd1) == len_r);

  // Next-state decode and the ready/busy value the next state implies.
  always_comb begin
    next_state_s = state_r;
    ready_next_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_ok_s) next_state_s = S_HDR;
        else            next_state_s = state_r;
      end
      S_HDR: begin
        if (accept_s) next_state_s = S_HI;
        else          next_state_s = S_HDR;
      end
      S_HI: begin
        if (accept_s) next_state_s = S_LO;
        else          next_state_s = S_HI;
      end
      S_LO: begin
        if (accept_s && last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
          next_state_s = S_CHK;
`else
          next_state_s = S_DONE;
`endif
        end else if (accept_s) begin
          next_state_s = S_HI;
        end else begin
          next_state_s = S_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_s) next_state_s = S_DONE;
        else          next_state_s = S_CHK;
      end
`endif
      default: next_state_s = S_IDLE;
    endcase

    case (next_state_s)
      S_HDR, S_HI, S_LO: ready_next_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:             ready_next_s = 1'b1;
`endif
      default:           ready_next_s = 1'b0;
    endcase
  end

  // Control state, registered status outputs and frame bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      word_count_r <= 9'd0;
      len_r        <= 9'd0;
      hi_r         <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      acc_r        <= 8'd0;
      error_r      <= 1'b0;
`endif
    end else begin
      state_r      <= next_state_s;
      byte_ready_r <= ready_next_s;
      busy_r       <= ready_next_s;
      done_r       <= (next_state_s == S_DONE);
      if (start_ok_s) begin
        word_count_r <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
        acc_r        <= 8'd0;
        error_r      <= 1'b0;
`endif
      end else if (accept_s) begin
        case (state_r)
          S_HDR: len_r <= {1'b0, stream.byte_in} + 9'd1;
          S_HI: begin
            hi_r <= stream.byte_in;
`ifdef LOADER_CHECKSUM_EN
            acc_r <= acc_r ^ stream.byte_in;
`endif
          end
          S_LO: begin
            word_count_r <= word_count_r + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            acc_r <= acc_r ^ stream.byte_in;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK: error_r <= (stream.byte_in != acc_r);
`endif
          default: len_r <= len_r;
        endcase
      end else begin
        word_count_r <= word_count_r;
      end
    end
  end

  // Word write on the LO-byte edge; contents survive reset and start.
  always_ff @(posedge clock) begin
    if (reset_n && accept_s && (state_r == S_LO)) begin
      mem_r[word_count_r[7:0]] <= {hi_r, stream.byte_in};
    end
  end

  assign stream.byte_ready = byte_ready_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign word_count        = word_count_r;
  assign data              = mem_r[address];
`ifdef LOADER_CHECKSUM_EN
  assign error             = error_r;
`else
  assign error             = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed + randomized bench for prog_loader with a
// word-array reference model of the program memory.
module tb_prog_loader;
  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  address;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic [8:0]  word_count;
  logic        error;

  prog_loader_if bif ();

  prog_loader #(.DEPTH(256)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stream     (bif.slave),
    .address    (address),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .error      (error)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] mm   [256];
  logic [15:0] wbuf [256];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running edge counter used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one byte after an idle gap; return after the edge that takes it.
  task automatic send_byte(input logic [7:0] b, input int gap_sel);
    int gap;
    int waited;
    logic rdy;
    gap = (gap_sel == 1) ? 1 : (gap_sel == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (gap) begin
      bif.byte_valid = 1'b0;
      bif.byte_in    = 8'hEE;
      tick();
    end
    bif.byte_valid = 1'b1;
    bif.byte_in    = b;
    waited = 0;
    forever begin
      rdy = bif.byte_ready;
      tick();
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        check("ready_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bif.byte_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      address = a[7:0];
      #0.1;
      check(tag, {16'd0, data}, {16'd0, mm[a]});
    end
  endtask

  // Load len words from wbuf; stop after n_send words if n_send < len.
  task automatic do_load(input int len, input int n_send, input int gap_sel,
                         input bit bad_ck, input bit start_mid);
    logic [7:0] acc;
    int         c0;
    bit         exp_err;
    acc = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, bif.byte_ready}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("wc_cleared", {23'd0, word_count}, 32'd0);
    send_byte(8'(len - 1), gap_sel);
    for (int i = 0; i < n_send; i++) begin
      if (start_mid && i == len / 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_busy", {31'd0, busy}, 32'd1);
        check("start_ignored_wc", {23'd0, word_count}, i);
      end
      send_byte(wbuf[i][15:8], gap_sel);
      send_byte(wbuf[i][7:0], gap_sel);
      mm[i] = wbuf[i];
      acc   = acc ^ wbuf[i][15:8] ^ wbuf[i][7:0];
      address = i[7:0];
      #0.1;
      check("word_visible", {16'd0, data}, {16'd0, wbuf[i]});
      check("wc_step", {23'd0, word_count}, i + 1);
    end
    if (n_send < len) return;
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_ck ? (acc ^ 8'h5A) : acc, gap_sel);
    exp_err = bad_ck;
    if (gap_sel == 0) check("latency", cyc - c0, 2 + 2 * len);
`else
    exp_err = 1'b0;
    if (gap_sel == 0) check("latency", cyc - c0, 1 + 2 * len);
`endif
    check("done_end", {31'd0, done}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("ready_end", {31'd0, bif.byte_ready}, 32'd0);
    check("wc_end", {23'd0, word_count}, len);
    check("error_end", {31'd0, error}, {31'd0, exp_err});
  endtask

  initial begin
    int len;
    for (int a = 0; a < 256; a++) mm[a] = 16'h0000;
    reset_n = 1'b0;
    start = 1'b0;
    address = 8'd0;
    bif.byte_in = 8'h00;
    bif.byte_valid = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'd0, bif.byte_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wc", {23'd0, word_count}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;

    // Idle with a valid stream and no start: nothing is accepted.
    bif.byte_valid = 1'b1;
    bif.byte_in = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready", {31'd0, bif.byte_ready}, 32'd0);
    end
    bif.byte_valid = 1'b0;
    check("idle_wc", {23'd0, word_count}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check_mem("idle_mem");

    // Basic two-word load.
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    do_load(2, 2, 0, 1'b0, 1'b0);
    check_mem("basic_mem");

    // Valid ignored in DONE; done held.
    bif.byte_valid = 1'b1;
    bif.byte_in = 8'hAA;
    repeat (5) tick();
    bif.byte_valid = 1'b0;
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_wc_hold", {23'd0, word_count}, 32'd2);
    check_mem("done_mem");

    // Same stream with alternating valid gaps and a start while busy.
    for (int a = 0; a < 2; a++) mm[a] = 16'h0000;
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    do_load(2, 2, 1, 1'b0, 1'b1);
    check_mem("bp_mem");

    // Full depth: header 0xFF, 256 words.
    for (int i = 0; i < 256; i++) wbuf[i] = 16'(i) ^ 16'h5A5A;
    do_load(256, 256, 0, 1'b0, 1'b0);
    check_mem("full_mem");

    // Randomized loads with random stalls and checksum outcomes.
    for (int n = 0; n < 5; n++) begin
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) wbuf[i] = 16'($urandom);
      do_load(len, len, 2, 1'($urandom_range(0, 1)), 1'b1);
      check_mem("rand_mem");
    end

    // Reset after 3 of 4 words.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom) | 16'h0001;
    wbuf[3] = mm[3] ^ 16'hFFFF;
    do_load(4, 3, 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_ready", {31'd0, bif.byte_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_wc", {23'd0, word_count}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    check_mem("abort_mem");

    // Recovery load after the abort.
    for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
    do_load(3, 3, 2, 1'b0, 1'b0);
    check_mem("recover_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
